// File: rtl/uart_hex_pkg.sv
// Shared types, ASCII constants and the nibble-to-ASCII helper used by the
// hex word sender that feeds the UART transmit path.
package uart_hex_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      GAP  = 2'd2
   } state_e;

   localparam logic [7:0] ASCII_ZERO    = 8'h30;
   localparam logic [7:0] ASCII_UPPER_A = 8'h41;
   localparam logic [7:0] ASCII_LOWER_A = 8'h61;
   localparam logic [7:0] ASCII_CR      = 8'h0D;
   localparam logic [7:0] ASCII_LF      = 8'h0A;

   function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nibble,
                                                  input logic       uppercase);
      logic [7:0] n8;
      n8 = {4'h0, nibble};
      if (nibble < 4'd10)
         return ASCII_ZERO + n8;
      else if (uppercase)
         return ASCII_UPPER_A + n8 - 8'd10;
      else
         return ASCII_LOWER_A + n8 - 8'd10;
   endfunction

endpackage

// File: rtl/uart_hex_word_sender.sv
// Prints a 16-bit word as ASCII hex (MS nibble first) into the ATX FIFO,
// one character per SEND/GAP pair. Define UART_HEX_CRLF_EN to append CR LF.
module uart_hex_word_sender
   import uart_hex_pkg::*;
#(
   parameter int NUM_DIGITS     = 4,
   parameter int UPPERCASE      = 1,
   parameter int SUPPRESS_ZEROS = 0
) (
   input  logic        sysclk,
   input  logic        sysreset,
   input  logic [15:0] word_in,
   input  logic        word_valid,
   output logic        word_ready,
   input  logic        atx_fifo_full,
   output logic [15:0] atx_data_out,
   output logic        atx_reg_load,
   output logic        busy
);

   if (NUM_DIGITS < 1 || NUM_DIGITS > 4) begin : g_bad_num_digits
      $error("uart_hex_word_sender: NUM_DIGITS must be 1..4");
   end

   // Handshake: a word transfers on any edge where word_valid && word_ready;
   // word_ready is low from that edge until the final character is written.
   state_e      state_q, state_d;
   logic [15:0] word_q, word_d;
   logic [1:0]  idx_q, idx_d;
   logic        ready_q, ready_d;
   logic        busy_q, busy_d;
   logic        load_q, load_d;
   logic [7:0]  data_q, data_d;
   logic [1:0]  start_idx;
   logic [3:0]  cur_nibble;
   logic [7:0]  cur_char;

`ifdef UART_HEX_CRLF_EN
   localparam logic [1:0] TRL_DIGITS = 2'd0;
   localparam logic [1:0] TRL_CR     = 2'd1;
   localparam logic [1:0] TRL_LF     = 2'd2;
   logic [1:0] trl_q, trl_d;
`endif

   // With zero suppression the first digit is the highest non-zero nibble.
   always_comb begin
      start_idx = 2'(NUM_DIGITS - 1);
      if (SUPPRESS_ZEROS != 0) begin
         start_idx = 2'd0;
         for (int i = 0; i < NUM_DIGITS; i++) begin
            if (word_in[4*i +: 4] != 4'h0) start_idx = 2'(i);
         end
      end
   end

   always_comb begin
      cur_nibble = word_q[{idx_q, 2'b00} +: 4];
      cur_char   = nibble_to_ascii(cur_nibble, UPPERCASE != 0);
`ifdef UART_HEX_CRLF_EN
      if (trl_q == TRL_CR) cur_char = ASCII_CR;
      else if (trl_q == TRL_LF) cur_char = ASCII_LF;
`endif
   end

   always_comb begin
      state_d = state_q;
      word_d  = word_q;
      idx_d   = idx_q;
      ready_d = ready_q;
      busy_d  = busy_q;
      load_d  = 1'b0;
      data_d  = data_q;
`ifdef UART_HEX_CRLF_EN
      trl_d   = trl_q;
`endif
      case (state_q)
         IDLE: begin
            if (word_valid && ready_q) begin
               word_d  = word_in;
               idx_d   = start_idx;
               ready_d = 1'b0;
               busy_d  = 1'b1;
               state_d = SEND;
`ifdef UART_HEX_CRLF_EN
               trl_d   = TRL_DIGITS;
`endif
            end
         end
         SEND: begin
            if (!atx_fifo_full) begin
               load_d  = 1'b1;
               data_d  = cur_char;
               state_d = GAP;
            end
         end
         GAP: begin
`ifdef UART_HEX_CRLF_EN
            if (trl_q == TRL_DIGITS && idx_q != 2'd0) begin
               idx_d   = idx_q - 2'd1;
               state_d = SEND;
            end else if (trl_q != TRL_LF) begin
               trl_d   = trl_q + 2'd1;
               state_d = SEND;
            end else begin
               ready_d = 1'b1;
               busy_d  = 1'b0;
               state_d = IDLE;
            end
`else
            if (idx_q != 2'd0) begin
               idx_d   = idx_q - 2'd1;
               state_d = SEND;
            end else begin
               ready_d = 1'b1;
               busy_d  = 1'b0;
               state_d = IDLE;
            end
`endif
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge sysclk) begin
      if (sysreset) begin
         state_q <= IDLE;
         word_q  <= 16'h0000;
         idx_q   <= 2'd0;
         ready_q <= 1'b1;
         busy_q  <= 1'b0;
         load_q  <= 1'b0;
         data_q  <= 8'h00;
`ifdef UART_HEX_CRLF_EN
         trl_q   <= TRL_DIGITS;
`endif
      end else begin
         state_q <= state_d;
         word_q  <= word_d;
         idx_q   <= idx_d;
         ready_q <= ready_d;
         busy_q  <= busy_d;
         load_q  <= load_d;
         data_q  <= data_d;
`ifdef UART_HEX_CRLF_EN
         trl_q   <= trl_d;
`endif
      end
   end

   assign word_ready   = ready_q;
   assign busy         = busy_q;
   assign atx_reg_load = load_q;
   assign atx_data_out = {8'h00, data_q};

endmodule

// File: tb/tb_uart_hex_word_sender.sv
// Directed bench for uart_hex_word_sender: three parameterisations, queue
// scoreboards with per-DUT monitors, plus latency/backpressure/reset checks.
module tb_uart_hex_word_sender;

   logic        sysclk = 1'b0;
   logic        sysreset = 1'b1;
   logic [15:0] word_in = 16'h0000;
   logic        valid_a = 1'b0, valid_b = 1'b0, valid_c = 1'b0;
   logic        full_a = 1'b0, full_bc = 1'b0;
   logic        ready_a, load_a, busy_a;
   logic        ready_b, load_b, busy_b;
   logic        ready_c, load_c, busy_c;
   logic [15:0] data_a, data_b, data_c;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int acc_cyc = 0;
   logic [15:0] exp_a[$];
   logic [15:0] exp_b[$];
   logic [15:0] exp_c[$];
   int strobe_cyc_a[$];
   logic full_seen_a = 1'b0;

`ifdef UART_HEX_CRLF_EN
   localparam int TRL = 2;
`else
   localparam int TRL = 0;
`endif

   uart_hex_word_sender #(.NUM_DIGITS(4), .UPPERCASE(1), .SUPPRESS_ZEROS(0)) dut_a (
      .sysclk(sysclk), .sysreset(sysreset), .word_in(word_in), .word_valid(valid_a),
      .word_ready(ready_a), .atx_fifo_full(full_a), .atx_data_out(data_a),
      .atx_reg_load(load_a), .busy(busy_a));

   uart_hex_word_sender #(.NUM_DIGITS(4), .UPPERCASE(0), .SUPPRESS_ZEROS(0)) dut_b (
      .sysclk(sysclk), .sysreset(sysreset), .word_in(word_in), .word_valid(valid_b),
      .word_ready(ready_b), .atx_fifo_full(full_bc), .atx_data_out(data_b),
      .atx_reg_load(load_b), .busy(busy_b));

   uart_hex_word_sender #(.NUM_DIGITS(4), .UPPERCASE(1), .SUPPRESS_ZEROS(1)) dut_c (
      .sysclk(sysclk), .sysreset(sysreset), .word_in(word_in), .word_valid(valid_c),
      .word_ready(ready_c), .atx_fifo_full(full_bc), .atx_data_out(data_c),
      .atx_reg_load(load_c), .busy(busy_c));

   // clock / reset
   always #5 sysclk = ~sysclk;

   always @(posedge sysclk) begin
      cyc <= cyc + 1;
      full_seen_a <= full_a;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic fail_now(input string name);
      checks++;
      failures++;
      $display("FAIL %s actual=timeout required=event", name);
   endtask

   // monitors
   always @(negedge sysclk) begin
      if (!sysreset && load_a) begin
         strobe_cyc_a.push_back(cyc);
         check("a_no_strobe_while_full", {31'd0, full_seen_a}, 32'd0);
         check("a_busy_during_strobe", {31'd0, busy_a}, 32'd1);
         if (exp_a.size() == 0) begin
            checks++; failures++;
            $display("FAIL a_unexpected_strobe actual=%0h required=none", data_a);
         end else check("a_char", {16'd0, data_a}, {16'd0, exp_a.pop_front()});
      end
   end

   always @(negedge sysclk) begin
      if (!sysreset && load_b) begin
         if (exp_b.size() == 0) begin
            checks++; failures++;
            $display("FAIL b_unexpected_strobe actual=%0h required=none", data_b);
         end else check("b_char", {16'd0, data_b}, {16'd0, exp_b.pop_front()});
      end
   end

   always @(negedge sysclk) begin
      if (!sysreset && load_c) begin
         if (exp_c.size() == 0) begin
            checks++; failures++;
            $display("FAIL c_unexpected_strobe actual=%0h required=none", data_c);
         end else check("c_char", {16'd0, data_c}, {16'd0, exp_c.pop_front()});
      end
   end

   // driver tasks
   task automatic step();
      @(negedge sysclk);
      #1;
   endtask

   function automatic logic rdy(input int w);
      case (w)
         0: return ready_a;
         1: return ready_b;
         default: return ready_c;
      endcase
   endfunction

   task automatic set_valid(input int w, input logic v);
      case (w)
         0: valid_a = v;
         1: valid_b = v;
         default: valid_c = v;
      endcase
   endtask

   task automatic push(input int w, input logic [15:0] v);
      case (w)
         0: exp_a.push_back(v);
         1: exp_b.push_back(v);
         default: exp_c.push_back(v);
      endcase
   endtask

   task automatic push_trl(input int w);
`ifdef UART_HEX_CRLF_EN
      push(w, 16'h000D);
      push(w, 16'h000A);
`else
      if (w < 0) push(w, 16'h0000);
`endif
   endtask

   function automatic int qsize(input int w);
      case (w)
         0: return exp_a.size();
         1: return exp_b.size();
         default: return exp_c.size();
      endcase
   endfunction

   task automatic accept(input int w, input logic [15:0] v);
      int n = 0;
      step();
      while (!rdy(w) && n < 300) begin step(); n++; end
      if (n >= 300) fail_now("accept_ready");
      word_in = v;
      set_valid(w, 1'b1);
      @(posedge sysclk);
      step();
      set_valid(w, 1'b0);
      acc_cyc = cyc;
   endtask

   task automatic wait_done(input int w, input string name);
      int n = 0;
      while (!(rdy(w) && qsize(w) == 0) && n < 300) begin step(); n++; end
      if (n >= 300) fail_now(name);
      check(name, qsize(w), 0);
   endtask

   task automatic wait_strobes(input int k, input string name);
      int n = 0;
      while (strobe_cyc_a.size() < k && n < 300) begin step(); n++; end
      if (n >= 300) fail_now(name);
   endtask

   initial begin
      int n;
      int rc;
      int fall;
      int nchar;

      repeat (3) @(posedge sysclk);
      step();
      sysreset = 1'b0;
      step();
      check("rst_ready_a", {31'd0, ready_a}, 32'd1);
      check("rst_busy_a", {31'd0, busy_a}, 32'd0);
      check("rst_load_a", {31'd0, load_a}, 32'd0);
      check("rst_data_a", {16'd0, data_a}, 32'd0);
      check("rst_ready_b", {31'd0, ready_b}, 32'd1);
      check("rst_ready_c", {31'd0, ready_c}, 32'd1);

      // 1A2F with latency and spacing
      nchar = 4 + TRL;
      strobe_cyc_a.delete();
      push(0, 16'h0031); push(0, 16'h0041); push(0, 16'h0032); push(0, 16'h0046);
      push_trl(0);
      accept(0, 16'h1A2F);
      check("lat_busy_after_accept", {31'd0, busy_a}, 32'd1);
      n = 0;
      while (!ready_a && n < 300) begin step(); n++; end
      if (n >= 300) fail_now("lat_ready_return");
      rc = cyc;
      check("lat_strobe_count", strobe_cyc_a.size(), nchar);
      for (int i = 0; i < nchar && i < strobe_cyc_a.size(); i++)
         check("lat_strobe_cycle", strobe_cyc_a[i], acc_cyc + 1 + 2 * i);
      check("lat_ready_cycle", rc, acc_cyc + 2 * nchar);
      check("lat_busy_released", {31'd0, busy_a}, 32'd0);
      wait_done(0, "a_1a2f_drained");

      // lowercase BEEF
      push(1, 16'h0062); push(1, 16'h0065); push(1, 16'h0065); push(1, 16'h0066);
      push_trl(1);
      accept(1, 16'hBEEF);
      wait_done(1, "b_beef_drained");

      // zero suppression
      push(2, 16'h0030);
      push_trl(2);
      accept(2, 16'h0000);
      wait_done(2, "c_0000_drained");
      push(2, 16'h0043); push(2, 16'h0033);
      push_trl(2);
      accept(2, 16'h00C3);
      wait_done(2, "c_00c3_drained");

      // backpressure on 1234
      strobe_cyc_a.delete();
      push(0, 16'h0031); push(0, 16'h0032); push(0, 16'h0033); push(0, 16'h0034);
      push_trl(0);
      accept(0, 16'h1234);
      wait_strobes(2, "bp_second_strobe");
      full_a = 1'b1;
      repeat (10) step();
      full_a = 1'b0;
      fall = cyc;
      wait_strobes(3, "bp_third_strobe");
      if (strobe_cyc_a.size() >= 3) check("bp_third_cycle", strobe_cyc_a[2], fall + 1);
      wait_done(0, "bp_drained");
      check("bp_strobe_count", strobe_cyc_a.size(), nchar);

      // reset mid-word on 5678
      strobe_cyc_a.delete();
      push(0, 16'h0035); push(0, 16'h0036);
      accept(0, 16'h5678);
      wait_strobes(2, "rst_mid_second_strobe");
      step();
      sysreset = 1'b1;
      step();
      check("rst_mid_load", {31'd0, load_a}, 32'd0);
      check("rst_mid_ready", {31'd0, ready_a}, 32'd1);
      check("rst_mid_busy", {31'd0, busy_a}, 32'd0);
      sysreset = 1'b0;
      repeat (4) step();
      check("rst_mid_strobe_count", strobe_cyc_a.size(), 2);
      check("rst_mid_queue", exp_a.size(), 0);
      push(0, 16'h0030); push(0, 16'h0030); push(0, 16'h0030); push(0, 16'h0039);
      push_trl(0);
      accept(0, 16'h0009);
      wait_done(0, "a_0009_drained");

      // 00FF with word_valid held high throughout
      step();
      strobe_cyc_a.delete();
      push(0, 16'h0030); push(0, 16'h0030); push(0, 16'h0046); push(0, 16'h0046);
      push_trl(0);
      word_in = 16'h00FF;
      valid_a = 1'b1;
      @(posedge sysclk);
      step();
      n = 0;
      while (!ready_a && n < 300) begin step(); n++; end
      if (n >= 300) fail_now("hold_ready_return");
      valid_a = 1'b0;
      check("hold_strobe_count", strobe_cyc_a.size(), nchar);
      if (strobe_cyc_a.size() > 0)
         check("hold_ready_after_last", cyc, strobe_cyc_a[strobe_cyc_a.size() - 1] + 1);
      check("hold_queue", exp_a.size(), 0);

      repeat (5) step();
      check("end_queue_a", exp_a.size(), 0);
      check("end_queue_b", exp_b.size(), 0);
      check("end_queue_c", exp_c.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/uart_hex_word_sender.md
Name: uart_hex_word_sender

Overview:
- Sysclk-domain stage directly upstream of the UART transmit path. Its outputs drive the UART's `data_in` / `atx_reg_load`.
- Accepts a 16-bit word over a valid/ready handshake and emits it as ASCII hex characters, most-significant nibble first, into the ATX FIFO.
- Throttles on the FIFO's `atx_fifo_full` status bit (`status_out[ATX_FIFO_FULL_BIT]`).
- Lets firmware or debug logic print register values without per-character CPU work.

Parameters:
- NUM_DIGITS, 4, number of low-order nibbles printed (1..4); out-of-range is an elaboration error.
- UPPERCASE, 1, 1 prints digits 10..15 as 0x41..0x46 ('A'..'F'); 0 prints them as 0x61..0x66 ('a'..'f').
- SUPPRESS_ZEROS, 0, 1 skips leading zero nibbles; at least one digit is always printed.

Ports:
- sysclk  in  1  system clock.
- sysreset  in  1  synchronous, active-high reset.
- word_in  in  16  value to print; sampled on the accept edge.
- word_valid  in  1  producer has a word.
- word_ready  out  1  block is idle and can accept a word.
- atx_fifo_full  in  1  ATX FIFO full flag, sysclk domain.
- atx_data_out  out  16  character to the UART `data_in`; bits [15:8] are always 0.
- atx_reg_load  out  1  one-cycle write strobe to the UART.
- busy  out  1  high from the accept edge until the last character's strobe has completed.

Behaviour:
- Single clock, sysclk. Reset is synchronous and active-high. All outputs are registered.
- Reset values: word_ready=1, busy=0, atx_reg_load=0, atx_data_out=0, state=IDLE, digit counter=0.
- Accept: on an edge where word_valid && word_ready:
  - capture word_in; set word_ready<=0, busy<=1; state<=SEND.
  - digit index <= NUM_DIGITS-1. With SUPPRESS_ZEROS, the index instead starts at the highest non-zero nibble, or 0 if the word is zero.
- Words offered while busy are not accepted; word_ready stays low.
- SEND: on an edge where atx_fifo_full==0:
  - atx_reg_load<=1; atx_data_out<={8'h00, ascii(nibble[index])}; state<=GAP.
  - If atx_fifo_full==1, hold in SEND with atx_reg_load=0 for as long as needed.
- GAP: next edge sets atx_reg_load<=0.
  - If characters remain, decrement the index (or advance the trailer pointer) and state<=SEND.
  - Otherwise state<=IDLE, word_ready<=1, busy<=0.
- The mandatory GAP lets the FIFO's registered full flag settle, so no write is issued against a stale flag.
- Maximum rate is one character per 2 sysclk cycles.
- Latency with the FIFO never full: first atx_reg_load is high in the 2nd cycle after the accept edge. Subsequent strobes follow every 2 cycles. word_ready returns 1 one cycle after the last strobe.
- ascii(n): n<10 → 0x30+n; otherwise 0x41+n-10 (UPPERCASE=1) or 0x61+n-10 (UPPERCASE=0).
- Only nibbles [NUM_DIGITS-1:0] are printed; higher bits of word_in are ignored.
- Reset mid-word: the next edge returns to reset values and the partial word is abandoned. Any strobe already issued is not retracted.
- Edge sampling: atx_fifo_full is sampled only in SEND. A full flag rising during GAP does not cancel the already-issued strobe.
- atx_data_out holds its last value while atx_reg_load=0.

Optional Feature:
- Macro: UART_HEX_CRLF_EN.
- Defined: after the last digit, two further characters 0x0D then 0x0A are sent. Each uses the same SEND/GAP throttling. busy and word_ready release only after the LF strobe.
- Undefined: digits only. No trailer logic or state bits are present in the netlist.

Decomposition:
- Shared package uart_hex_pkg holds:
  - state enum typedef {IDLE, SEND, GAP};
  - constants ASCII_ZERO=8'h30, ASCII_UPPER_A=8'h41, ASCII_LOWER_A=8'h61, ASCII_CR=8'h0D, ASCII_LF=8'h0A;
  - function nibble_to_ascii(nibble, uppercase).
- No sub-module: the conversion is a package function and the FSM is a single module.

Test Plan:
- word_in=16'h1A2F, NUM_DIGITS=4, UPPERCASE=1, full=0 → strobes carry 0x31, 0x41, 0x32, 0x46, spaced 2 cycles apart. First strobe is 2 cycles after accept; word_ready returns 1 one cycle after the 4th strobe.
- UPPERCASE=0, word_in=16'hBEEF → 0x62, 0x65, 0x65, 0x66.
- SUPPRESS_ZEROS=1: word_in=16'h0000 → single 0x30. word_in=16'h00C3 → 0x43, 0x33 only.
- Backpressure on 16'h1234: atx_fifo_full=1 for 10 cycles just after the 2nd strobe → no strobe while full. Third strobe 0x33 follows the first SEND edge after full falls; exactly 4 strobes in total, none lost or duplicated.
- sysreset pulsed 1 cycle after the 2nd strobe of 16'h5678 → atx_reg_load=0, word_ready=1, busy=0 on the next edge. A new word 16'h0009 then prints 0x30, 0x30, 0x30, 0x39.
- UART_HEX_CRLF_EN defined, word_in=16'h00FF → 0x30, 0x30, 0x46, 0x46, 0x0D, 0x0A. word_valid held high throughout is accepted only after the 0x0A strobe.
